// File: rtl/fsm_bcd_pkg.sv
// Shared definitions for the BCD counter / display mux: FSM state encodings
// and active-low 7-segment patterns ({g,f,e,d,c,b,a}).
package fsm_bcd_pkg;

  typedef enum logic [1:0] {
    S_RST  = 2'b00,
    S_RUN  = 2'b01,
    S_HOLD = 2'b10
  } state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/fsm_bcd_cnt_mux_seg7_dec.sv
// BCD digit to active-low 7-segment decoder; non-BCD codes blank the digit.
module seg7_dec
  import fsm_bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/fsm_bcd_cnt_mux.sv
// Prescaled up/down BCD counter with run/hold FSM and a multiplexed 7-segment scan.
// Define FSM_BCD_CNT_MUX_LZB_EN to blank leading zero digits on the display.
module fsm_bcd_cnt_mux
  import fsm_bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50000000,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    pause,
  input  logic                    up_dn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    tc,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              led_7
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

  state_e                  state_q, state_d;
  logic [PW-1:0]           pre_q, pre_d;
  logic [4*NUM_DIGITS-1:0] cnt_q, cnt_d, cnt_step, ld_clean;
  logic                    tc_q, tc_d;
  logic [SW-1:0]           scan_q, scan_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    step, wrap, blank;
  logic [3:0]              cur_digit;
  logic [6:0]              seg;

  always_comb begin
    state_d = S_RST;
    case (state_q)
      S_RST:   state_d = S_RUN;
      S_RUN:   state_d = pause ? S_HOLD : S_RUN;
      S_HOLD:  state_d = pause ? S_HOLD : S_RUN;
      default: state_d = S_RST;
    endcase
    if (clr) state_d = S_RST;
  end

  // Ripple the +/-1 through the digits; a carry out of the top digit is a full wrap.
  always_comb begin
    logic carry;
    carry    = 1'b1;
    cnt_step = cnt_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (up_dn) begin
          if (cnt_q[4*i +: 4] >= 4'd9) cnt_step[4*i +: 4] = 4'd0;
          else begin
            cnt_step[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (cnt_q[4*i +: 4] == 4'd0) cnt_step[4*i +: 4] = 4'd9;
          else begin
            cnt_step[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    wrap = carry;
  end

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++)
      ld_clean[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
  end

  always_comb begin
    step  = (state_q == S_RUN) && (pre_q == PRE_MAX);
    cnt_d = cnt_q;
    pre_d = pre_q;
    tc_d  = 1'b0;
    if (clr) begin
      cnt_d = '0;
      pre_d = '0;
    end else if (load) begin
      cnt_d = ld_clean;
      pre_d = '0;
    end else begin
      case (state_q)
        S_RUN:   pre_d = step ? '0 : pre_q + 1'b1;
        S_HOLD:  pre_d = pre_q;
        default: pre_d = '0;
      endcase
      if (step) begin
        cnt_d = cnt_step;
        tc_d  = wrap;
      end
    end
  end

  // Display scan runs independently of the counter control inputs.
  always_comb begin
    scan_d = (scan_q == SCAN_MAX) ? '0 : scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SCAN_MAX) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RST;
      pre_q   <= '0;
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      scan_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx_q == IW'(i)) cur_digit = cnt_q[4*i +: 4];
  end

`ifdef FSM_BCD_CNT_MUX_LZB_EN
  // Blank when every digit from the scanned one upward is zero; digit 0 always shows.
  always_comb begin
    blank = (idx_q != '0);
    for (int i = 0; i < NUM_DIGITS; i++)
      if ((IW'(i) >= idx_q) && (cnt_q[4*i +: 4] != 4'd0)) blank = 1'b0;
  end
`else
  assign blank = 1'b0;
`endif

  seg7_dec u_dec (
    .digit (cur_digit),
    .seg   (seg)
  );

  assign count = cnt_q;
  assign tc    = tc_q;
  assign an    = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q);
  assign led_7 = blank ? SEG_BLANK : seg;

endmodule

// File: tb/tb_fsm_bcd_cnt_mux.sv
// Scoreboard bench: two 2-digit instances (TICK_DIV 1 and 3) share stimulus and
// are checked against an integer-valued reference model.
module tb_fsm_bcd_cnt_mux;

  localparam int N  = 2;
  localparam int SD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, clr = 1'b0, pause = 1'b0, up_dn = 1'b1, load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] c1, c3;
  logic       t1, t3;
  logic [1:0] an1, an3;
  logic [6:0] l1, l3;

  fsm_bcd_cnt_mux #(.NUM_DIGITS(N), .TICK_DIV(1), .SCAN_DIV(SD)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .pause(pause), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(c1), .tc(t1), .an(an1), .led_7(l1));

  fsm_bcd_cnt_mux #(.NUM_DIGITS(N), .TICK_DIV(3), .SCAN_DIV(SD)) dut3 (
    .clk(clk), .rst(rst), .clr(clr), .pause(pause), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(c3), .tc(t3), .an(an3), .led_7(l3));

  typedef struct packed {
    logic [7:0] c1;
    logic       t1;
    logic [7:0] c3;
    logic       t3;
    logic [1:0] an;
    logic [6:0] l1;
    logic [6:0] l3;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;

  // Reference model: count kept as a plain integer 0..99; mode 0=reset,1=run,2=hold.
  int td[2] = '{1, 3};
  int mst[2], pre[2], val[2];
  bit mtc[2];
  int scan_k;
  logic [6:0] segs [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic logic [7:0] to_bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int sanit(logic [7:0] lv);
    int hi, lo;
    hi = (lv[7:4] > 9) ? 0 : int'(lv[7:4]);
    lo = (lv[3:0] > 9) ? 0 : int'(lv[3:0]);
    return hi * 10 + lo;
  endfunction

  function automatic logic [6:0] led_ref(int v, int idx);
    int d;
    d = (idx == 0) ? v % 10 : v / 10;
`ifdef FSM_BCD_CNT_MUX_LZB_EN
    if (idx == 1 && v / 10 == 0) return 7'b1111111;
`endif
    return segs[d];
  endfunction

  task automatic cyc(input bit r, input bit c, input bit p, input bit u, input bit l,
                     input logic [7:0] lv);
    exp_t e;
    int idx;
    rst = r; clr = c; pause = p; up_dn = u; load = l; load_val = lv;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (r || c) begin
        mst[i] = 0; pre[i] = 0; val[i] = 0; mtc[i] = 0;
      end else begin
        bit step;
        int nst;
        step   = (mst[i] == 1) && (pre[i] == td[i] - 1);
        nst    = (mst[i] == 0) ? 1 : (p ? 2 : 1);
        mtc[i] = 0;
        if (l) begin
          val[i] = sanit(lv);
          pre[i] = 0;
        end else begin
          if (mst[i] == 1) pre[i] = (pre[i] + 1) % td[i];
          if (step) begin
            if (u) begin mtc[i] = (val[i] == 99); val[i] = (val[i] + 1) % 100; end
            else   begin mtc[i] = (val[i] == 0);  val[i] = (val[i] + 99) % 100; end
          end
        end
        mst[i] = nst;
      end
    end
    scan_k = r ? 0 : scan_k + 1;
    idx    = (scan_k / SD) % N;
    e.c1 = to_bcd(val[0]); e.t1 = mtc[0];
    e.c3 = to_bcd(val[1]); e.t3 = mtc[1];
    e.an = (idx == 0) ? 2'b10 : 2'b01;
    e.l1 = led_ref(val[0], idx);
    e.l3 = led_ref(val[1], idx);
    q.push_back(e);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("count_div1", c1, e.c1);
        chk("tc_div1", {7'd0, t1}, {7'd0, e.t1});
        chk("count_div3", c3, e.c3);
        chk("tc_div3", {7'd0, t3}, {7'd0, e.t3});
        chk("an_div1", {6'd0, an1}, {6'd0, e.an});
        chk("an_div3", {6'd0, an3}, {6'd0, e.an});
        chk("led_div1", {1'b0, l1}, {1'b0, e.l1});
        chk("led_div3", {1'b0, l3}, {1'b0, e.l3});
      end
    end
  end

  initial begin
    bit p, u;
    // Reset then free-run upward through a full wrap
    cyc(1, 0, 0, 1, 0, 8'h00);
    repeat (101) cyc(0, 0, 0, 1, 0, 8'h00);
    // Count down from 95 through 00 -> 99
    cyc(0, 0, 0, 0, 1, 8'h95);
    repeat (100) cyc(0, 0, 0, 0, 0, 8'h00);
    // Non-BCD digit loads as zero
    cyc(0, 0, 0, 1, 1, 8'hA7);
    repeat (4) cyc(0, 0, 0, 1, 0, 8'h00);
    // Pause mid-prescale, then release
    cyc(0, 0, 0, 1, 1, 8'h10);
    repeat (2) cyc(0, 0, 0, 1, 0, 8'h00);
    repeat (5) cyc(0, 0, 1, 1, 0, 8'h00);
    repeat (6) cyc(0, 0, 0, 1, 0, 8'h00);
    // clr beats load at count 42
    cyc(0, 0, 1, 1, 1, 8'h42);
    cyc(0, 1, 1, 1, 1, 8'h99);
    repeat (3) cyc(0, 0, 0, 1, 0, 8'h00);
    // rst in hold at 57 discards a concurrent load
    cyc(0, 0, 1, 1, 1, 8'h57);
    repeat (3) cyc(0, 0, 1, 1, 0, 8'h00);
    cyc(1, 0, 1, 1, 1, 8'h33);
    repeat (3) cyc(0, 0, 1, 1, 0, 8'h00);
    // Static 05: scan both digits
    cyc(0, 0, 1, 1, 1, 8'h05);
    repeat (10) cyc(0, 0, 1, 1, 0, 8'h00);
    // Random traffic
    p = 0; u = 1;
    repeat (3000) begin
      if ($urandom_range(0, 19) == 0) p = ~p;
      if ($urandom_range(0, 39) == 0) u = ~u;
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0, p, u,
          $urandom_range(0, 29) == 0, 8'($urandom));
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d expected=0 entries left", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
